sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_pkg.sv | 18 +
 rtl/sipo_out_reg.sv | 49 ++++
 rtl/sipo_deser.sv | 112 +++++++++++
 tb/tb_sipo_deser.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// The PAR state exists only when SIPO_DESER_PARITY_EN is defined.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

`ifdef SIPO_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    // Even-parity bit: the value that makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// Output holding register for sipo_deser: valid/ready handshake, sticky overrun
// and the parity-error flag that travels with the held word.
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             perr,
    input  logic             out_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             overrun,
    output logic             parity_err
);

    logic accept;

    // A completed word is taken if the slot is empty or being drained this cycle.
    assign accept = load && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (accept) begin
                out        <= word;
                parity_err <= perr;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (load && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with start-bit framing and a held output.
// Define SIPO_DESER_PARITY_EN to append an even-parity bit after each word.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             shift,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             busy,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word_nxt;
    logic [CW-1:0]    bit_pos;
    logic [CW-1:0]    tgt;
    logic             complete;
    logic             perr_nxt;
    logic [WIDTH-1:0] load_word;

    // Bit position of the incoming din; a start always lands at bit 0.
    always_comb begin
        bit_pos  = (start || state == IDLE) ? '0 : cnt;
        tgt      = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - bit_pos) : bit_pos;
        word_nxt = sreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (CW'(i) == tgt) word_nxt[i] = din;
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    assign complete  = shift && !start && (state == PAR);
    assign load_word = sreg;
    assign perr_nxt  = din ^ even_parity(64'(sreg));
`else
    assign complete  = shift && !start && (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    assign load_word = word_nxt;
    assign perr_nxt  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (shift) begin
            if (start) begin
                sreg  <= word_nxt;
                cnt   <= CW'(1);
                state <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        sreg <= word_nxt;
                        if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_DESER_PARITY_EN
                            cnt   <= cnt + CW'(1);
                            state <= PAR;
`else
                            cnt   <= '0;
                            state <= IDLE;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
`ifdef SIPO_DESER_PARITY_EN
                    PAR: begin
                        cnt   <= '0;
                        state <= IDLE;
                    end
`endif
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (complete),
        .word      (load_word),
        .perr      (perr_nxt),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out       (out),
        .out_valid (out_valid),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances driven in parallel
// against a queue-based word model; honours SIPO_DESER_PARITY_EN.
module tb_sipo_deser;

    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic din = 1'b0, shift = 1'b0, start = 1'b0, out_ready = 1'b1, ovr_clr = 1'b0;

    logic [W-1:0] out_m, out_l;
    logic ov_m, ov_l, or_m, or_l, busy_m, busy_l, pe_m, pe_l;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .din(din), .shift(shift), .start(start),
        .out(out_m), .out_valid(ov_m), .out_ready(out_ready), .overrun(or_m),
        .ovr_clr(ovr_clr), .busy(busy_m), .parity_err(pe_m)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .shift(shift), .start(start),
        .out(out_l), .out_valid(ov_l), .out_ready(out_ready), .overrun(or_l),
        .ovr_clr(ovr_clr), .busy(busy_l), .parity_err(pe_l)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bits of the word being received, in arrival order.
    bit           q[$];
    bit           active = 1'b0;
    logic [W-1:0] mout_m = '0, mout_l = '0;
    logic         mvalid = 1'b0, movr = 1'b0, mperr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit           complete = 1'b0;
        logic [W-1:0] wm = '0, wl = '0;
        logic         pe = 1'b0;
        int           ones = 0;
        if (reset) begin
            q.delete();
            active = 1'b0;
            mout_m = '0; mout_l = '0;
            mvalid = 1'b0; movr = 1'b0; mperr = 1'b0;
        end else begin
            if (shift) begin
                if (start) begin
                    q.delete();
                    q.push_back(din);
                    active = 1'b1;
                end else if (active) begin
`ifdef SIPO_DESER_PARITY_EN
                    if (q.size() == W) complete = 1'b1;
                    else q.push_back(din);
`else
                    q.push_back(din);
                    if (q.size() == W) complete = 1'b1;
`endif
                end
            end
            if (complete) begin
                for (int i = 0; i < W; i++) begin
                    wm = wm * 2 + W'(q[i]);
                    wl = wl | (W'(q[i]) << i);
                    ones += int'(q[i]);
                end
`ifdef SIPO_DESER_PARITY_EN
                pe = (din != logic'(ones % 2));
`endif
                q.delete();
                active = 1'b0;
            end
            if (complete && mvalid && !out_ready) movr = 1'b1;
            else if (ovr_clr) movr = 1'b0;
            if (complete && (!mvalid || out_ready)) begin
                mout_m = wm; mout_l = wl; mvalid = 1'b1; mperr = pe;
            end else if (out_ready) begin
                mvalid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("msb_out",   32'(out_m),  32'(mout_m));
        check("msb_valid", 32'(ov_m),   32'(mvalid));
        check("msb_ovr",   32'(or_m),   32'(movr));
        check("msb_busy",  32'(busy_m), 32'(active));
        check("msb_perr",  32'(pe_m),   32'(mperr));
        check("lsb_out",   32'(out_l),  32'(mout_l));
        check("lsb_valid", 32'(ov_l),   32'(mvalid));
        check("lsb_ovr",   32'(or_l),   32'(movr));
        check("lsb_busy",  32'(busy_l), 32'(active));
        check("lsb_perr",  32'(pe_l),   32'(mperr));
    endtask

    task automatic send_bit(input logic b, input logic st);
        din = b; shift = 1'b1; start = st;
        step();
        shift = 1'b0; start = 1'b0;
    endtask

    // v[W-1] is sent first; out_ready takes rdy_last on the completing edge.
    task automatic send_word(input logic [W-1:0] v, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
`ifndef SIPO_DESER_PARITY_EN
            if (i == W - 1) out_ready = rdy_last;
`endif
            send_bit(v[W-1-i], i == 0);
        end
`ifdef SIPO_DESER_PARITY_EN
        out_ready = rdy_last;
        send_bit(^v, 1'b0);
`endif
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        step();
        step();
        check("rst_out",   32'(out_m),  32'h0);
        check("rst_valid", 32'(ov_m),   32'h0);
        check("rst_ovr",   32'(or_m),   32'h0);
        check("rst_busy",  32'(busy_m), 32'h0);
        check("rst_perr",  32'(pe_m),   32'h0);
        reset = 1'b0;
        step();

        // Shift without start while idle is ignored
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("idle_ignore_busy", 32'(busy_m), 32'h0);

        // Basic word, both bit orders; out_valid lasts one cycle with out_ready=1
        out_ready = 1'b1;
        send_word(4'b1011, 1'b1);
        check("w1011_msb",   32'(out_m), 32'hB);
        check("w1011_lsb",   32'(out_l), 32'hD);
        check("w1011_valid", 32'(ov_m),  32'h1);
        step();
        check("w1011_drop_valid", 32'(ov_m), 32'h0);

        // Overrun: held word kept, second word dropped, then cleared
        out_ready = 1'b0;
        send_word(4'b1011, 1'b0);
        send_word(4'b0110, 1'b0);
        check("ovr_out_kept", 32'(out_m), 32'hB);
        check("ovr_set",      32'(or_m),  32'h1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(or_m), 32'h0);
        check("ovr_valid_held", 32'(ov_m), 32'h1);

        // Completion on the same edge the held word is consumed
        out_ready = 1'b0;
        send_word(4'b0110, 1'b1);
        check("swap_out",   32'(out_m), 32'h6);
        check("swap_valid", 32'(ov_m),  32'h1);
        check("swap_ovr",   32'(or_m),  32'h0);
        out_ready = 1'b1;
        step();

        // Reset mid-word discards partial bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", 32'(busy_m), 32'h0);
        send_word(4'b0011, 1'b1);
        check("midrst_out", 32'(out_m), 32'h3);

        // Start after two bits restarts the word
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_word(4'b0101, 1'b1);
        check("restart_out", 32'(out_m), 32'h5);
        check("restart_lsb", 32'(out_l), 32'hA);
        step();

`ifdef SIPO_DESER_PARITY_EN
        // Good and bad parity on 1011
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("par_good_perr", 32'(pe_m), 32'h0);
        step();
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("par_bad_perr", 32'(pe_m), 32'h1);
        check("par_bad_out",  32'(out_m), 32'hB);
        step();
`endif

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 299) == 0);
            din       = 1'($urandom);
            shift     = ($urandom_range(0, 3) != 0);
            start     = shift && ($urandom_range(0, 6) == 0);
            out_ready = ($urandom_range(0, 1) == 0);
            ovr_clr   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
